// File: rtl/encoder_pkg.sv
// Shared state type, default geometry and index-width helper for the
// encoder front-end sequencer.
package encoder_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    localparam int DEF_INPUT_NUM      = 400;
    localparam int DEF_IN_WIDTH       = 12;
    localparam int DEF_OUT_NUM        = 16;
    localparam int DEF_OUTPUT_WIDTH   = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // A single-entry index still needs one bit to exist as a signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W  = idx_width(DEF_INPUT_NUM);
    localparam int DEF_OIDX_W = idx_width(DEF_OUT_NUM);
    localparam int DEF_TMO_W  = idx_width(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/encoder_sequencer_latent_serializer.sv
// Captures the encoder's latent vector on a strobe and unloads it one
// element per valid/ready beat, signalling the FSM when the last beat goes.
module latent_serializer
    import encoder_pkg::*;
#(
    parameter int OUT_NUM      = DEF_OUT_NUM,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            capture,
    input  logic [OUTPUT_WIDTH*OUT_NUM-1:0] lat_in,
    input  logic                            m_ready,
    output logic                            m_valid,
    output logic [OUTPUT_WIDTH-1:0]         m_data,
    output logic                            m_last,
    output logic                            done
);

    localparam int OIDX_W = idx_width(OUT_NUM);

    logic [OUTPUT_WIDTH*OUT_NUM-1:0] latent_q, latent_d;
    logic [OIDX_W-1:0]               oidx_q, oidx_d;
    logic                            m_valid_q, m_valid_d;
    logic [OUTPUT_WIDTH-1:0]         m_data_q, m_data_d;
    logic                            m_last_q, m_last_d;

    always_comb begin
        latent_d  = latent_q;
        oidx_d    = oidx_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        done      = m_valid_q & m_ready & m_last_q;

        if (capture) begin
            latent_d  = lat_in;
            oidx_d    = '0;
            m_valid_d = 1'b1;
            m_data_d  = lat_in[0 +: OUTPUT_WIDTH];
            m_last_d  = (OUT_NUM == 1);
        end else if (m_valid_q && m_ready) begin
            if (m_last_q) begin
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                oidx_d    = '0;
            end else begin
                // m_data is registered, so the next element is fetched on accept.
                oidx_d   = oidx_q + 1'b1;
                m_data_d = latent_q[oidx_d*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                m_last_d = (oidx_d == OIDX_W'(OUT_NUM - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latent_q  <= '0;
            oidx_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            latent_q  <= latent_d;
            oidx_q    <= oidx_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule

// File: rtl/encoder_sequencer.sv
// Front-end controller for the encoder: pixel loader, start pulse,
// completion wait with timeout, and latent stream-out.
//
//   state | meaning
//   LOAD  | accept pixel beats into enc_x, check frame length
//   START | one-cycle enc_valid pulse, clear wait counter
//   WAIT  | wait for rising enc_ready, abort after TIMEOUT_CYCLES
//   DRAIN | serialize captured latents on the m_* stream
module encoder_sequencer
    import encoder_pkg::*;
#(
    parameter int INPUT_NUM      = DEF_INPUT_NUM,
    parameter int IN_WIDTH       = DEF_IN_WIDTH,
    parameter int OUT_NUM        = DEF_OUT_NUM,
    parameter int OUTPUT_WIDTH   = DEF_OUTPUT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [IN_WIDTH-1:0]             s_data,
    input  logic                            s_last,
    output logic                            enc_valid,
    output logic [IN_WIDTH*INPUT_NUM-1:0]   enc_x,
    input  logic [OUTPUT_WIDTH*OUT_NUM-1:0] enc_out,
    input  logic                            enc_ready,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [OUTPUT_WIDTH-1:0]         m_data,
    output logic                            m_last,
    output logic                            busy,
    output logic                            err_frame,
    output logic                            err_timeout
);

    localparam int IDX_W = idx_width(INPUT_NUM);
    localparam int TMO_W = idx_width(TIMEOUT_CYCLES);

    seq_state_e                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [TMO_W-1:0]              wait_cnt_q, wait_cnt_d;
    logic [IN_WIDTH*INPUT_NUM-1:0] enc_x_q, enc_x_d;
    logic                          s_ready_q, s_ready_d;
    logic                          enc_valid_q, enc_valid_d;
    logic                          busy_q, busy_d;
    logic                          err_frame_q, err_frame_d;
    logic                          err_timeout_q, err_timeout_d;
    logic                          enc_ready_hist_q;
    logic                          ready_rise;
    logic                          at_end;
    logic                          capture;
    logic                          drain_done;

    assign ready_rise = enc_ready & ~enc_ready_hist_q;
    assign at_end     = (idx_q == IDX_W'(INPUT_NUM - 1));

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_cnt_d    = wait_cnt_q;
        enc_x_d       = enc_x_q;
        s_ready_d     = s_ready_q;
        enc_valid_d   = 1'b0;
        busy_d        = busy_q;
        err_frame_d   = 1'b0;
        err_timeout_d = 1'b0;
        capture       = 1'b0;

        case (state_q)
            LOAD: begin
                if (s_valid && s_ready_q) begin
                    if (at_end && s_last) begin
                        enc_x_d[idx_q*IN_WIDTH +: IN_WIDTH] = s_data;
                        idx_d       = '0;
                        state_d     = START;
                        s_ready_d   = 1'b0;
                        enc_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else if (at_end || s_last) begin
                        // Mis-framed beat is dropped; stale enc_x is overwritten by the next frame.
                        err_frame_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        enc_x_d[idx_q*IN_WIDTH +: IN_WIDTH] = s_data;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (ready_rise) begin
                    capture = 1'b1;
                    state_d = DRAIN;
                end else if (wait_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout_d = 1'b1;
                    idx_d         = '0;
                    state_d       = LOAD;
                    s_ready_d     = 1'b1;
                    busy_d        = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d   = LOAD;
                    s_ready_d = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: begin
                state_d   = LOAD;
                idx_d     = '0;
                s_ready_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= LOAD;
            idx_q            <= '0;
            wait_cnt_q       <= '0;
            enc_x_q          <= '0;
            s_ready_q        <= 1'b1;
            enc_valid_q      <= 1'b0;
            busy_q           <= 1'b0;
            err_frame_q      <= 1'b0;
            err_timeout_q    <= 1'b0;
            enc_ready_hist_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            wait_cnt_q       <= wait_cnt_d;
            enc_x_q          <= enc_x_d;
            s_ready_q        <= s_ready_d;
            enc_valid_q      <= enc_valid_d;
            busy_q           <= busy_d;
            err_frame_q      <= err_frame_d;
            err_timeout_q    <= err_timeout_d;
            enc_ready_hist_q <= enc_ready;
        end
    end

    latent_serializer #(
        .OUT_NUM      (OUT_NUM),
        .OUTPUT_WIDTH (OUTPUT_WIDTH)
    ) u_latent_serializer (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .lat_in  (enc_out),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (drain_done)
    );

    assign s_ready     = s_ready_q;
    assign enc_valid   = enc_valid_q;
    assign enc_x       = enc_x_q;
    assign busy        = busy_q;
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_encoder_sequencer.sv
// Directed bench for encoder_sequencer: framing, start pulse, edge-qualified
// completion, timeout, stalled drain and mid-operation reset.
module tb_encoder_sequencer;

    localparam int NPIX = 400;
    localparam int PW   = 12;
    localparam int NOUT = 16;
    localparam int OW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [PW-1:0]     s_data;
    logic              s_last;
    logic              enc_valid;
    logic [PW*NPIX-1:0] enc_x;
    logic [OW*NOUT-1:0] enc_out;
    logic              enc_ready;
    logic              m_valid;
    logic              m_ready;
    logic [OW-1:0]     m_data;
    logic              m_last;
    logic              busy;
    logic              err_frame;
    logic              err_timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int n_enc_valid  = 0;
    int n_mvalid_cyc = 0;
    logic [OW-1:0] beat_q[$];
    logic          last_q[$];

    encoder_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .enc_valid   (enc_valid),
        .enc_x       (enc_x),
        .enc_out     (enc_out),
        .enc_ready   (enc_ready),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .err_frame   (err_frame),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle (outputs plus the inputs driven for it), then advance.
    task automatic tick();
        if (enc_valid === 1'b1) n_enc_valid++;
        if (m_valid === 1'b1) n_mvalid_cyc++;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            beat_q.push_back(m_data);
            last_q.push_back(m_last);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pix(input int i, input int mul, input int add);
        return PW'((i * mul + add) % 4096);
    endfunction

    function automatic logic [OW-1:0] lat(input int k, input int mul, input int add);
        return OW'((k * mul + add) % 256);
    endfunction

    task automatic send_frame(input int nbeats, input int last_at, input int mul, input int add);
        for (int i = 0; i < nbeats; i++) begin
            s_valid = 1'b1;
            s_data  = pix(i, mul, add);
            s_last  = (i == last_at);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_enc_x(input string tag, input int mul, input int add);
        int bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (enc_x[i*PW +: PW] !== pix(i, mul, add)) bad++;
        check(tag, bad, 0);
    endtask

    task automatic set_enc_out(input int mul, input int add);
        for (int k = 0; k < NOUT; k++) enc_out[k*OW +: OW] = lat(k, mul, add);
    endtask

    // Called in the START cycle with enc_ready low; raises it `delay` cycles later.
    task automatic enc_complete(input int delay, input int mul, input int add);
        set_enc_out(mul, add);
        tick();
        check("enc_valid_one_cycle", enc_valid, 0);
        repeat (delay - 1) tick();
        enc_ready = 1'b1;
        tick();
        check("capture_m_valid", m_valid, 1);
        check("capture_m_data0", m_data, lat(0, mul, add));
    endtask

    task automatic drain(input int mode, input int mul, input int add);
        int bad_sready = 0;
        int bad_stable = 0;
        int bad_data = 0;
        int bad_last = 0;
        int cyc = 0;
        logic stalled;
        logic [OW-1:0] held;
        logic [3:0] patv = 4'b1001;
        beat_q.delete();
        last_q.delete();
        while (beat_q.size() < NOUT && cyc < 200) begin
            m_ready = (mode == 0) ? 1'b1 : patv[cyc % 4];
            if (s_ready !== 1'b0) bad_sready++;
            stalled = (m_valid === 1'b1) && !m_ready;
            held    = m_data;
            tick();
            if (stalled && m_data !== held) bad_stable++;
            cyc++;
        end
        m_ready = 1'b0;
        check("drain_beats", beat_q.size(), NOUT);
        check("drain_s_ready_low", bad_sready, 0);
        check("drain_stall_stable", bad_stable, 0);
        check("drain_end_s_ready", s_ready, 1);
        check("drain_end_busy", busy, 0);
        check("drain_end_m_valid", m_valid, 0);
        for (int k = 0; k < beat_q.size(); k++) begin
            if (beat_q[k] !== lat(k, mul, add)) bad_data++;
            if (last_q[k] !== (k == NOUT - 1)) bad_last++;
        end
        check("drain_data_order", bad_data, 0);
        check("drain_m_last", bad_last, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"}, s_ready, 1);
        check({tag, "_enc_valid"}, enc_valid, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err_frame"}, err_frame, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_enc_x"}, (enc_x == '0), 1);
    endtask

    initial begin
        int ev0;
        int mv0;
        int cnt;
        logic busy_prev;

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        enc_out = '0; enc_ready = 1'b0; m_ready = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Nominal frame: pixel i = i, latents k*3, completion 3 cycles after start.
        ev0 = n_enc_valid;
        send_frame(NPIX, NPIX - 1, 1, 0);
        check("t1_enc_valid", enc_valid, 1);
        check("t1_s_ready", s_ready, 0);
        check("t1_busy", busy, 1);
        check_enc_x("t1_enc_x", 1, 0);
        enc_complete(3, 3, 0);
        drain(0, 3, 0);
        check("t1_enc_valid_count", n_enc_valid - ev0, 1);
        enc_ready = 1'b0;
        tick();

        // Short frame (s_last on beat 199) and long frame (no s_last at beat 399).
        ev0 = n_enc_valid;
        send_frame(200, 199, 1, 0);
        check("t2_err_frame_short", err_frame, 1);
        check("t2_busy_short", busy, 0);
        tick();
        check("t2_err_frame_pulse", err_frame, 0);
        send_frame(NPIX, -1, 1, 0);
        check("t2_err_frame_long", err_frame, 1);
        check("t2_s_ready_long", s_ready, 1);
        tick();
        send_frame(NPIX, NPIX - 1, 3, 7);
        check("t2_enc_valid", enc_valid, 1);
        check_enc_x("t2_enc_x", 3, 7);
        enc_complete(2, 5, 9);
        drain(0, 5, 9);
        check("t2_enc_valid_count", n_enc_valid - ev0, 1);
        enc_ready = 1'b0;
        tick();

        // Timeout: enc_ready never rises.
        send_frame(NPIX, NPIX - 1, 2, 1);
        mv0 = n_mvalid_cyc;
        cnt = 0;
        busy_prev = 1'b0;
        while (err_timeout !== 1'b1 && cnt < 1100) begin
            busy_prev = busy;
            tick();
            cnt++;
        end
        check("t3_timeout_latency", cnt, 1025);
        check("t3_busy_before", busy_prev, 1);
        check("t3_busy_after", busy, 0);
        check("t3_s_ready", s_ready, 1);
        check("t3_no_beats", n_mvalid_cyc - mv0, 0);
        tick();
        check("t3_timeout_pulse", err_timeout, 0);

        // Stale high enc_ready must not complete; the next rise captures the new data.
        enc_ready = 1'b1;
        tick();
        send_frame(NPIX, NPIX - 1, 1, 5);
        set_enc_out(2, 100);
        mv0 = n_mvalid_cyc;
        repeat (4) tick();
        check("t4_stale_no_valid", n_mvalid_cyc - mv0, 0);
        check("t4_stale_busy", busy, 1);
        enc_ready = 1'b0;
        tick();
        set_enc_out(5, 1);
        enc_ready = 1'b1;
        tick();
        check("t4_rise_m_valid", m_valid, 1);
        check("t4_rise_m_data", m_data, lat(0, 5, 1));
        drain(0, 5, 1);
        enc_ready = 1'b0;
        tick();

        // Back-pressured drain with m_ready pattern 1,0,0,1.
        send_frame(NPIX, NPIX - 1, 7, 11);
        enc_complete(2, 13, 20);
        drain(1, 13, 20);
        enc_ready = 1'b0;
        tick();

        // Reset while in WAIT, then an enc_ready rise in LOAD must be ignored.
        ev0 = n_enc_valid;
        send_frame(NPIX, NPIX - 1, 1, 3);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset("t6_rst_wait");
        rst = 1'b0;
        mv0 = n_mvalid_cyc;
        enc_ready = 1'b1;
        repeat (4) tick();
        check("t6_wait_no_m_valid", n_mvalid_cyc - mv0, 0);
        check("t6_wait_enc_valid_count", n_enc_valid - ev0, 1);
        enc_ready = 1'b0;
        tick();

        // Reset while beat 7 of the drain is presented.
        send_frame(NPIX, NPIX - 1, 1, 0);
        enc_complete(2, 3, 1);
        beat_q.delete();
        last_q.delete();
        cnt = 0;
        m_ready = 1'b1;
        while (beat_q.size() < 7 && cnt < 50) begin
            tick();
            cnt++;
        end
        m_ready = 1'b0;
        check("t6_drain_beats_before_rst", beat_q.size(), 7);
        check("t6_drain_beat7_data", m_data, lat(7, 3, 1));
        rst = 1'b1;
        tick();
        check_reset("t6_rst_drain");
        rst = 1'b0;
        enc_ready = 1'b0;
        ev0 = n_enc_valid;
        mv0 = n_mvalid_cyc;
        m_ready = 1'b1;
        repeat (3) tick();
        m_ready = 1'b0;
        check("t6_drain_no_m_valid", n_mvalid_cyc - mv0, 0);
        check("t6_drain_no_enc_valid", n_enc_valid - ev0, 0);

        // Fresh frame after reset.
        send_frame(NPIX, NPIX - 1, 5, 9);
        check("t6_fresh_enc_valid", enc_valid, 1);
        check_enc_x("t6_fresh_enc_x", 5, 9);
        enc_complete(1, 9, 2);
        drain(0, 9, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_sequencer.md
Name: encoder_sequencer

Overview:
Front-end controller for the `encoder` datapath: loads one 12-bit pixel per beat into the 400-element vector, fires the encoder's one-cycle `valid`, waits for `out_ready`, and serializes the 16 latent outputs on a valid/ready stream.
Sits between the pixel DMA stream and `encoder`; owns the encoder's `valid` and `x` inputs.
Guards the exchange with frame-length checking and a completion timeout.

Parameters:
INPUT_NUM, 400, pixels per frame
IN_WIDTH, 12, pixel width (Q3.9)
OUT_NUM, 16, latent outputs per frame
OUTPUT_WIDTH, 8, latent width (Q3.5)
TIMEOUT_CYCLES, 1024, maximum WAIT cycles before abort

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
s_valid  in  1  pixel beat valid
s_ready  out  1  pixel beat accepted when s_valid&s_ready
s_data  in  IN_WIDTH  pixel value
s_last  in  1  marks final pixel of frame
enc_valid  out  1  one-cycle start pulse to encoder
enc_x  out  IN_WIDTH*INPUT_NUM  assembled vector; pixel i at [i*IN_WIDTH +: IN_WIDTH]
enc_out  in  OUTPUT_WIDTH*OUT_NUM  encoder outputs, flattened, out[k] at [k*OUTPUT_WIDTH +: OUTPUT_WIDTH]
enc_ready  in  1  encoder out_ready (level)
m_valid  out  1  latent beat valid
m_ready  in  1  downstream accept
m_data  out  OUTPUT_WIDTH  latent value, index order 0..OUT_NUM-1
m_last  out  1  high on beat OUT_NUM-1
busy  out  1  high in any state except LOAD
err_frame  out  1  one-cycle pulse on framing error
err_timeout  out  1  one-cycle pulse on encoder timeout

Behaviour:
- Reset values: state=LOAD, pixel index=0, s_ready=1, enc_valid=0, m_valid=0, m_last=0, busy=0, err_*=0, enc_x=0, wait counter=0, out index=0, enc_ready history=0.
- Reset mid-operation aborts the frame; no enc_valid or m_valid is issued afterwards.
- LOAD:
  - s_ready=1. Each accepted beat writes enc_x slice[idx], then idx++.
  - Beat with idx==INPUT_NUM-1 and s_last=1 -> START.
  - s_last=1 with idx<INPUT_NUM-1, or idx==INPUT_NUM-1 with s_last=0 -> err_frame pulse next cycle, idx=0, remain LOAD; the beat itself is dropped.
  - enc_x is not cleared on error; it is overwritten by the next frame.
- START:
  - s_ready=0. enc_valid=1 for exactly this one cycle, which is the cycle after the last accepted beat.
  - Wait counter cleared. Next state is WAIT.
- WAIT:
  - Completion is the rising edge of enc_ready (enc_ready=1 and previous-cycle enc_ready=0); a stale high level never completes a frame.
  - On completion, enc_out is captured into an internal latent register -> DRAIN.
  - Counter increments every WAIT cycle. On reaching TIMEOUT_CYCLES-1 without an edge: err_timeout pulse, idx=0 -> LOAD, no output beats.
  - An edge on the same cycle as timeout counts as completion.
- DRAIN:
  - m_valid=1 from the first DRAIN cycle (capture edge +1). m_data = latent[oidx]; m_last=(oidx==OUT_NUM-1).
  - oidx advances only on m_valid&m_ready; m_data is held stable while stalled.
  - Accept of the last beat -> LOAD, s_ready=1 on the next cycle. Upstream is back-pressured for the whole of START/WAIT/DRAIN.
- enc_ready edges seen outside WAIT are ignored; enc_ready history updates every cycle.
- No arithmetic beyond counters. Index counters are $clog2(INPUT_NUM), $clog2(OUT_NUM) and $clog2(TIMEOUT_CYCLES) bits and never wrap within a frame.
- Minimum frame period is INPUT_NUM + 2 + encoder latency + OUT_NUM cycles.

Decomposition:
- Package encoder_pkg:
  - state enum {LOAD, START, WAIT, DRAIN}
  - IN_WIDTH/OUTPUT_WIDTH/INPUT_NUM/OUT_NUM defaults
  - index-width localparams via $clog2
- One sub-module, latent_serializer:
  - capture strobe, OUT_NUM-entry register, valid/ready unloader with m_last
  - done pulse back to the FSM
- The FSM, pixel loader and timeout counter stay in encoder_sequencer.

Test Plan:
1. 400 beats, pixel i = i mod 4096, s_last on beat 399; encoder model asserts enc_ready 3 cycles after enc_valid with out[k]=k*3 -> enc_x[i] = i; exactly one enc_valid pulse, on the cycle after beat 399; m_data = 0,3,...,45 with m_last on beat 15.
2. Frame with s_last on beat 199 -> err_frame one pulse; next full 400-beat frame completes normally with no extra enc_valid.
3. enc_ready never rises -> err_timeout after 1024 WAIT cycles, busy low next cycle, zero m_valid beats.
4. enc_ready held high from before START -> no completion until it drops and rises again; data is captured on that rise.
5. m_ready toggled 1,0,0,1 during DRAIN -> m_data stable while stalled; 16 beats delivered in order; s_ready=0 until the last beat is accepted.
6. rst asserted in WAIT and in DRAIN beat 7 -> all outputs at reset values the next cycle; a fresh frame then runs correctly.
